// File: rtl/capture_axi_pkg.sv
// ----------------------------------------------------------------------------
// capture_axi_pkg
// Shared definitions for the capture-core AXI4-Lite configuration slave:
// response codes, register map, register count and the write/read channel
// FSM state types.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

package capture_axi_pkg;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register map (byte offsets); slots 4..7 are unmapped
    localparam int         NUM_REGS    = 4;
    localparam logic [7:0] REG0_OFFSET = 8'h00;
    localparam logic [7:0] REG1_OFFSET = 8'h04;
    localparam logic [7:0] REG2_OFFSET = 8'h08;
    localparam logic [7:0] REG3_OFFSET = 8'h0C;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT_W,
        W_WAIT_A,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/capture_axi_lite_slave.sv
// ----------------------------------------------------------------------------
// capture_axi_lite_slave
// AXI4-Lite slave exposing four 32-bit read/write configuration registers to
// the capture core. Write and read channels run independent FSMs, each with at
// most one transaction outstanding.
//
// Ports
//   ACLK, ARESET            clock, asynchronous active-high reset
//   S_AXI_AW* / S_AXI_W*    write address / write data channels
//   S_AXI_B*                write response channel
//   S_AXI_AR* / S_AXI_R*    read address / read data channels
//   cfg_regs                registers 0..3 packed, reg n at [32n+31:32n]
//   reg_wr_stb              one-cycle pulse per register after a write commit
//
// Build option
//   CAPTURE_AXI_SLVERR_EN   when defined, accesses to unmapped slots (0x10-0x1C)
//                           answer SLVERR; otherwise they answer OKAY. Either
//                           way unmapped writes are dropped and reads return 0.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module capture_axi_lite_slave
    import capture_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                                   ACLK,
    input  logic                                   ARESET,
    // write address
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    // write data
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    // write response
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    // read address
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    // read data
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    // capture core side
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] cfg_regs,
    output logic [NUM_REGS-1:0]                    reg_wr_stb
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int BW = DW / 8;
    localparam int SW = AW - 2;               // word-slot index width
    localparam int IW = $clog2(NUM_REGS);     // register index width
    localparam logic [NUM_REGS-1:0] SEL_REG0 = 1;

`ifdef CAPTURE_AXI_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    w_state_t          r_wstate, w_wstate_nxt;
    r_state_t          r_rstate, w_rstate_nxt;
    logic              r_rdy_en;

    logic [AW-1:0]     r_awaddr;
    logic [DW-1:0]     r_wdata;
    logic [BW-1:0]     r_wstrb;
    logic [DW-1:0]     r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_stb;
    logic [1:0]        r_bresp;
    logic [1:0]        r_rresp;
    logic [DW-1:0]     r_rdata;

    logic              w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [AW-1:0]     w_c_addr;
    logic [DW-1:0]     w_c_data;
    logic [BW-1:0]     w_c_strb;
    logic [SW-1:0]     w_wslot, w_rslot;
    logic              w_wslot_ok, w_rslot_ok;
    logic [IW-1:0]     w_widx, w_ridx;
    logic [NUM_REGS-1:0] w_wr_sel;
    logic              w_unused_ok;

    function automatic logic slot_in_range(input logic [SW-1:0] slot);
        return int'(slot) < NUM_REGS;
    endfunction

    // Byte-lane merge: lanes with the strobe clear keep their old contents
    function automatic logic [DW-1:0] merge_strb(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [BW-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < BW; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    // Readies are held low until the first edge after reset release
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_rdy_en <= 1'b0;
        else        r_rdy_en <= 1'b1;
    end

    // ---------------- write channel FSM ----------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_wstate <= W_IDLE;
        else        r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt  = r_wstate;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                S_AXI_AWREADY = r_rdy_en;
                S_AXI_WREADY  = r_rdy_en;
                if (r_rdy_en) begin
                    if (S_AXI_AWVALID && S_AXI_WVALID) w_wstate_nxt = W_RESP;
                    else if (S_AXI_AWVALID)            w_wstate_nxt = W_WAIT_W;
                    else if (S_AXI_WVALID)             w_wstate_nxt = W_WAIT_A;
                end
            end
            W_WAIT_W: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID) w_wstate_nxt = W_RESP;
            end
            W_WAIT_A: begin
                S_AXI_AWREADY = 1'b1;
                if (S_AXI_AWVALID) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    assign w_aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID  & S_AXI_WREADY;

    // The write commits on the edge that completes the second of the two
    // handshakes; whichever half arrived earlier comes from the holding regs.
    assign w_commit = ((r_wstate == W_IDLE)   & w_aw_hs & w_w_hs) |
                      ((r_wstate == W_WAIT_W) & w_w_hs) |
                      ((r_wstate == W_WAIT_A) & w_aw_hs);
    assign w_c_addr = (r_wstate == W_WAIT_W) ? r_awaddr : S_AXI_AWADDR;
    assign w_c_data = (r_wstate == W_WAIT_A) ? r_wdata  : S_AXI_WDATA;
    assign w_c_strb = (r_wstate == W_WAIT_A) ? r_wstrb  : S_AXI_WSTRB;

    assign w_wslot    = w_c_addr[AW-1:2];
    assign w_wslot_ok = slot_in_range(w_wslot);
    assign w_widx     = w_wslot[IW-1:0];
    assign w_wr_sel   = (w_commit && w_wslot_ok) ? (SEL_REG0 << w_widx) : '0;

    always_ff @(posedge ACLK) begin
        if (w_aw_hs) r_awaddr <= S_AXI_AWADDR;
        if (w_w_hs) begin
            r_wdata <= S_AXI_WDATA;
            r_wstrb <= S_AXI_WSTRB;
        end
    end

    // ---------------- register bank / write response ----------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int n = 0; n < NUM_REGS; n++) r_regs[n] <= '0;
            r_wr_stb <= '0;
            r_bresp  <= RESP_OKAY;
        end else begin
            r_wr_stb <= w_wr_sel;
            for (int n = 0; n < NUM_REGS; n++) begin
                if (w_wr_sel[n]) r_regs[n] <= merge_strb(r_regs[n], w_c_data, w_c_strb);
            end
            if (w_commit) r_bresp <= w_wslot_ok ? RESP_OKAY : OOR_RESP;
        end
    end

    assign S_AXI_BRESP = r_bresp;
    assign reg_wr_stb  = r_wr_stb;

    always_comb begin
        cfg_regs = '0;
        for (int n = 0; n < NUM_REGS; n++) cfg_regs[DW*n +: DW] = r_regs[n];
    end

    // ---------------- read channel FSM ----------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_rstate <= R_IDLE;
        else        r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt  = r_rstate;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                S_AXI_ARREADY = r_rdy_en;
                if (r_rdy_en && S_AXI_ARVALID) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    assign w_ar_hs    = S_AXI_ARVALID & S_AXI_ARREADY;
    assign w_rslot    = S_AXI_ARADDR[AW-1:2];
    assign w_rslot_ok = slot_in_range(w_rslot);
    assign w_ridx     = w_rslot[IW-1:0];

    // Sampled from r_regs before the same-edge write lands, so a colliding
    // read returns the pre-write value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            if (w_rslot_ok) begin
                r_rdata <= r_regs[w_ridx];
                r_rresp <= RESP_OKAY;
            end else begin
                r_rdata <= '0;
                r_rresp <= OOR_RESP;
            end
        end
    end

    assign S_AXI_RDATA = r_rdata;
    assign S_AXI_RRESP = r_rresp;

    assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], w_c_addr[1:0]};

endmodule

// File: tb/tb_capture_axi_lite_slave.sv
`timescale 1ns/1ps

module tb_capture_axi_lite_slave;

    localparam logic [1:0] OKAY = 2'b00;
`ifdef CAPTURE_AXI_SLVERR_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif
    localparam int TMO = 50;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [4:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [4:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] cfg_regs;
    logic [3:0]   reg_wr_stb;

    int checks = 0;
    int failures = 0;

    logic [1:0]  q_bresp[$];
    logic [33:0] q_rd[$];
    logic [3:0]  q_stb[$];

    capture_axi_lite_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .cfg_regs(cfg_regs), .reg_wr_stb(reg_wr_stb)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout got=no_handshake exp=handshake", name);
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents output
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (q_bresp.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bresp_unexpected got=%0h exp=none", S_AXI_BRESP);
                end else check("bresp", {126'd0, S_AXI_BRESP}, {126'd0, q_bresp.pop_front()});
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (q_rd.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL read_unexpected got=%0h exp=none", {S_AXI_RRESP, S_AXI_RDATA});
                end else check("rresp_rdata", {94'd0, S_AXI_RRESP, S_AXI_RDATA}, {94'd0, q_rd.pop_front()});
            end
            if (reg_wr_stb != 4'b0) begin
                if (q_stb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wr_stb_unexpected got=%0h exp=none", reg_wr_stb);
                end else check("reg_wr_stb", {124'd0, reg_wr_stb}, {124'd0, q_stb.pop_front()});
            end
        end
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] exp_resp, input logic [3:0] exp_stb);
        int n;
        q_bresp.push_back(exp_resp);
        if (exp_stb != 4'b0) q_stb.push_back(exp_stb);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < TMO);
        if (!(S_AXI_AWREADY && S_AXI_WREADY)) timeout_fail("aw_w_ready");
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!S_AXI_BVALID && n < TMO);
        if (!S_AXI_BVALID) timeout_fail("bvalid");
        @(posedge ACLK); #1;
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] exp_d, input logic [1:0] exp_resp);
        int n;
        q_rd.push_back({exp_resp, exp_d});
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!S_AXI_ARREADY && n < TMO);
        if (!S_AXI_ARREADY) timeout_fail("arready");
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!S_AXI_RVALID && n < TMO);
        if (!S_AXI_RVALID) timeout_fail("rvalid");
        @(posedge ACLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;

        // reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_awready", {127'd0, S_AXI_AWREADY}, 128'd0);
        check("rst_wready",  {127'd0, S_AXI_WREADY},  128'd0);
        check("rst_arready", {127'd0, S_AXI_ARREADY}, 128'd0);
        check("rst_bvalid",  {127'd0, S_AXI_BVALID},  128'd0);
        check("rst_rvalid",  {127'd0, S_AXI_RVALID},  128'd0);
        check("rst_cfg_regs", cfg_regs, 128'd0);
        check("rst_rdata",   {96'd0, S_AXI_RDATA},    128'd0);
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        check("awready_before_first_edge", {127'd0, S_AXI_AWREADY}, 128'd0);
        @(negedge ACLK);
        check("awready_after_first_edge", {127'd0, S_AXI_AWREADY}, 128'd1);
        check("wready_after_first_edge",  {127'd0, S_AXI_WREADY},  128'd1);
        check("arready_after_first_edge", {127'd0, S_AXI_ARREADY}, 128'd1);
        @(posedge ACLK); #1;

        // write/read each register
        axi_write(5'h00, 32'h0101FFFF, 4'hF, OKAY, 4'b0001);
        axi_write(5'h04, 32'hABCD0001, 4'hF, OKAY, 4'b0010);
        axi_write(5'h08, 32'hDEAD0011, 4'hF, OKAY, 4'b0100);
        axi_write(5'h0C, 32'hBEEF0011, 4'hF, OKAY, 4'b1000);
        axi_read(5'h00, 32'h0101FFFF, OKAY);
        axi_read(5'h04, 32'hABCD0001, OKAY);
        axi_read(5'h08, 32'hDEAD0011, OKAY);
        axi_read(5'h0C, 32'hBEEF0011, OKAY);
        check("cfg_regs_packed", cfg_regs, {32'hBEEF0011, 32'hDEAD0011, 32'hABCD0001, 32'h0101FFFF});

        // partial strobe
        axi_write(5'h00, 32'h12345678, 4'b0101, OKAY, 4'b0001);
        axi_read(5'h00, 32'h0134FF78, OKAY);

        // zero strobe: no change, still pulses and responds
        axi_write(5'h08, 32'hFFFFFFFF, 4'b0000, OKAY, 4'b0100);
        axi_read(5'h08, 32'hDEAD0011, OKAY);

        // W two cycles ahead of AW, BREADY held low
        q_stb.push_back(4'b0010);
        q_bresp.push_back(OKAY);
        S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        check("wait_a_wready",  {127'd0, S_AXI_WREADY},  128'd0);
        check("wait_a_awready", {127'd0, S_AXI_AWREADY}, 128'd1);
        @(posedge ACLK); #1;
        S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check("bvalid_held", {127'd0, S_AXI_BVALID}, 128'd1);
            check("bresp_held",  {126'd0, S_AXI_BRESP},  128'd0);
        end
        @(posedge ACLK); #1 S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        axi_read(5'h04, 32'hCAFEF00D, OKAY);

        // unmapped slot
        axi_write(5'h14, 32'h11111111, 4'hF, EXP_OOR, 4'b0000);
        axi_read(5'h14, 32'h0, EXP_OOR);
        axi_read(5'h1C, 32'h0, EXP_OOR);
        check("cfg_regs_after_oor", cfg_regs, {32'hBEEF0011, 32'hDEAD0011, 32'hCAFEF00D, 32'h0134FF78});

        // read and write to the same register on the same edge
        fork
            axi_write(5'h04, 32'h55AA55AA, 4'hF, OKAY, 4'b0010);
            axi_read(5'h04, 32'hCAFEF00D, OKAY);
        join
        axi_read(5'h04, 32'h55AA55AA, OKAY);

        // address bits [1:0] ignored
        axi_read(5'h07, 32'h55AA55AA, OKAY);
        axi_write(5'h0E, 32'h00000077, 4'b0001, OKAY, 4'b1000);
        axi_read(5'h0C, 32'hBEEF0077, OKAY);

        // reset while waiting for write data
        S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        @(negedge ACLK);
        check("wait_w_awready", {127'd0, S_AXI_AWREADY}, 128'd0);
        check("wait_w_wready",  {127'd0, S_AXI_WREADY},  128'd1);
        #2 ARESET = 1'b1;
        #1;
        check("midrst_ready", {125'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 128'd0);
        check("midrst_valid", {126'd0, S_AXI_BVALID, S_AXI_RVALID}, 128'd0);
        check("midrst_cfg_regs", cfg_regs, 128'd0);
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        check("post_rst_awready_early", {127'd0, S_AXI_AWREADY}, 128'd0);
        @(negedge ACLK);
        check("post_rst_awready", {127'd0, S_AXI_AWREADY}, 128'd1);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_no_bvalid", {127'd0, S_AXI_BVALID}, 128'd0);
            @(negedge ACLK);
        end
        @(posedge ACLK); #1;
        axi_read(5'h08, 32'h0, OKAY);

        repeat (4) @(posedge ACLK);
        check("q_bresp_drained", 128'(q_bresp.size()), 128'd0);
        check("q_rd_drained",    128'(q_rd.size()),    128'd0);
        check("q_stb_drained",   128'(q_stb.size()),   128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/capture_axi_lite_slave.md
CAPTURE_AXI_LITE_SLAVE -- requirements
Module: capture_axi_lite_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width covering 8 word slots.
REQ-003 ACLK  in  1  sole clock; one clock, all logic on rising edge.
REQ-004 ARESET  in  1  reset, asynchronous, active-high.
REQ-005 S_AXI_AWADDR in ADDR_W; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1: write address channel.
REQ-006 S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1: write data channel.
REQ-007 S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1: write response channel.
REQ-008 S_AXI_ARADDR in ADDR_W; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1: read address channel.
REQ-009 S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1: read data channel.
REQ-010 cfg_regs  out  128  registers 0..3 packed, reg n at [32n+31:32n], to the capture core.
REQ-011 reg_wr_stb  out  4  one-cycle pulse per register on write commit.

Function
REQ-012 Decode SHALL use address bits [ADDR_W-1:2]; slots 0-3 (0x00-0x0C) valid RW, slots 4-7 (0x10-0x1C) out of range; bits [1:0] ignored.
REQ-013 Write FSM states W_IDLE, W_WAIT_W, W_WAIT_A, W_RESP; W_IDLE: AWREADY=1, WREADY=1.
REQ-014 W_IDLE with AW and W handshake same cycle: register updated on that edge, next state W_RESP.
REQ-015 W_IDLE with only AW: address latched, go W_WAIT_W (AWREADY=0, WREADY=1); only W: data/strobe latched, go W_WAIT_A (AWREADY=1, WREADY=0).
REQ-016 W_WAIT_W/W_WAIT_A: on the missing handshake commit the write on that edge and go W_RESP.
REQ-017 W_RESP: BVALID=1, both readies 0; BVALID/BRESP held stable until BREADY, then W_IDLE; minimum 2 cycles per write.
REQ-018 Commit SHALL update only bytes with WSTRB set; WSTRB=0 leaves register unchanged but still pulses reg_wr_stb and returns a response.
REQ-019 reg_wr_stb[n] SHALL be high for exactly the cycle after the commit edge for a valid slot n; never for out-of-range slots.
REQ-020 Read FSM states R_IDLE (ARREADY=1), R_DATA (ARREADY=0, RVALID=1); AR handshake latches RDATA/RRESP, go R_DATA; RREADY returns to R_IDLE.
REQ-021 Read latency SHALL be 1 cycle, AR handshake to RVALID; RDATA/RRESP stable while RVALID && !RREADY.
REQ-022 Read and write commit on the same edge to the same register: read returns pre-write value.
REQ-023 Read and write FSMs SHALL be independent; at most one outstanding transaction per direction.

Reset
REQ-024 Asserting ARESET SHALL immediately force cfg_regs=0, reg_wr_stb=0, all READY/VALID=0, BRESP=RRESP=0, RDATA=0, FSMs to idle.
REQ-025 AWREADY, WREADY, ARREADY SHALL first assert on the first rising edge after ARESET deasserts.
REQ-026 Reset mid-transaction SHALL abandon it without response; no partial register update.

Configuration
REQ-027 Macro CAPTURE_AXI_SLVERR_EN defined: out-of-range write gets BRESP=2'b10 and no update; out-of-range read gets RRESP=2'b10, RDATA=0.
REQ-028 CAPTURE_AXI_SLVERR_EN undefined: out-of-range write ignored with BRESP=OKAY; read returns 0 with RRESP=OKAY.

Structure
REQ-029 Package capture_axi_pkg SHALL hold RESP_OKAY/RESP_SLVERR, register offsets 0x00-0x0C, NUM_REGS=4 and write/read FSM state typedefs.
REQ-030 Single module, no sub-module; write and read FSMs as separate always blocks.

Verification
REQ-031 Write 0x0101FFFF@0x00, 0xabcd0001@0x04, 0xdead0011@0x08, 0xbeef0011@0x0C, each read back -> equal data, all responses OKAY, reg_wr_stb pulses 1,2,4,8.
REQ-032 W two cycles before AW, then BREADY low 3 cycles -> WREADY drops after W, BVALID held 3 cycles, single commit.
REQ-033 Reg0=0x0101FFFF, write 0x12345678 WSTRB=4'b0101 -> reads 0x0134FF78.
REQ-034 Write@0x14 -> SLVERR, regs unchanged with macro; OKAY, 0 read without.
REQ-035 Read 0x04 and write 0x55AA55AA commit same edge -> RDATA=old value; next read 0x55AA55AA.
REQ-036 ARESET asserted during W_WAIT_W -> outputs zero immediately; after release, AWREADY=1 next edge, no BVALID.
